// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the Mini SRC CPU: fetch/execute
// sequencing with ready-handshaked memory and a retired-instruction counter.
module control_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin_en,
    output logic        Rout_en,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] opcode;
    logic       is_alu;
    logic       is_imm;
    logic       is_ldi;
    logic       is_ld;
    logic       is_st;
    logic       is_nop;
    logic       is_halt;
    logic       is_mem;
    logic       is_exec;
    logic       is_bad;
    logic [4:0] imm_op;
    logic       retire;
    logic       unused_ir_bits;

    // Only the opcode field matters to the sequencer; register fields go to the datapath.
    assign opcode         = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];

    assign is_alu  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    assign is_imm  = (opcode >= 5'b01100) && (opcode <= 5'b01110);
    assign is_ldi  = (opcode == 5'b00001);
    assign is_ld   = (opcode == 5'b00000);
    assign is_st   = (opcode == 5'b00010);
    assign is_nop  = (opcode == 5'b11010);
    assign is_halt = (opcode == 5'b11011);
    assign is_mem  = is_ld | is_st;
    assign is_exec = is_alu | is_imm | is_ldi | is_mem;
    assign is_bad  = ~(is_exec | is_nop | is_halt);

    // Immediate forms reuse the matching register-form ALU operation.
    always_comb begin
        imm_op = 5'b00011;
        case (opcode)
            5'b01101: imm_op = 5'b00101;
            5'b01110: imm_op = 5'b00110;
            default:  imm_op = 5'b00011;
        endcase
    end

    // State register; reset parks the machine in RST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_RST;
        else          state <= next_state;
    end

    // An instruction retires when control returns to T0 or drops into HALT from T2.
    assign retire = (state != ST_RST) &&
                    ((next_state == ST_T0) || (state == ST_T2 && next_state == ST_HALT));

    // Retired-instruction counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    instr_count <= 16'd0;
        else if (retire) instr_count <= instr_count + 16'd1;
    end

    // Next-state and strobe decode from state, opcode and memory handshake.
    always_comb begin
        next_state = state;
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        PCin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Cout = 1'b0; Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin_en = 1'b0; Rout_en = 1'b0; BAout = 1'b0;
        alu_op = 5'b00000;
        illegal = 1'b0;
        run = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_RST: next_state = ST_T0;
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                alu_op = 5'b00011;
                next_state = ST_T1;
            end
            ST_T1: begin
                Read = 1'b1;
                if (mem_ready) begin
                    MDRin = 1'b1; Zlowout = 1'b1; PCin = 1'b1;
                    next_state = ST_T2;
                end
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                illegal = is_bad;
                if (is_exec)      next_state = ST_T3;
                else if (is_halt) next_state = ST_HALT;
                else              next_state = ST_T0;
            end
            ST_T3: begin
                Grb = 1'b1; Rout_en = 1'b1; Yin = 1'b1;
                BAout = is_ldi | is_mem;
                next_state = ST_T4;
            end
            ST_T4: begin
                Zin = 1'b1;
                if (is_alu) begin
                    Grc = 1'b1; Rout_en = 1'b1;
                    alu_op = opcode;
                end else if (is_imm) begin
                    Cout = 1'b1;
                    alu_op = imm_op;
                end else begin
                    Cout = 1'b1;
                    alu_op = 5'b00011;
                end
                next_state = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (is_mem) begin
                    MARin = 1'b1;
                    next_state = ST_T6;
                end else begin
                    Gra = 1'b1; Rin_en = 1'b1;
                    next_state = ST_T0;
                end
            end
            ST_T6: begin
                if (is_st) begin
                    Gra = 1'b1; Rout_en = 1'b1; MDRin = 1'b1;
                    next_state = ST_T7;
                end else begin
                    Read = 1'b1;
                    if (mem_ready) begin
                        MDRin = 1'b1;
                        next_state = ST_T7;
                    end
                end
            end
            ST_T7: begin
                MDRout = 1'b1;
                if (is_st) begin
                    Write = 1'b1;
                    if (mem_ready) next_state = ST_T0;
                end else begin
                    Gra = 1'b1; Rin_en = 1'b1;
                    next_state = ST_T0;
                end
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_RST;
        endcase
    end

endmodule
